// File: rtl/me_pkg.sv
// Shared sizes, address widths and FSM state type for the motion-estimator
// memory server.
package me_pkg;

  localparam int R_SIZE     = 256;
  localparam int S_SIZE     = 961;
  localparam int PIX_W      = 8;
  localparam int R_AW       = 8;
  localparam int S_AW       = 10;
  localparam int WDOG_LIMIT = 4095;
  localparam int WDOG_W     = 13;

  // Load-counter values of the final byte of each block (counter is S_AW wide).
  localparam logic [S_AW-1:0] R_LAST = S_AW'(R_SIZE - 1);
  localparam logic [S_AW-1:0] S_LAST = S_AW'(S_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_R,
    LOAD_S,
    RUN,
    HOLD
  } me_state_t;

endpackage

// File: rtl/me_frame_ram.sv
// Frame memory with one write port and NRD registered read ports; reads past
// DEPTH return zero instead of wrapping.
module me_frame_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int NRD   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  // Storage itself is never reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] q;

    assign addr = raddr[p*AW +: AW];
    assign rdata[p*DW +: DW] = q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if ({1'b0, addr} < DEPTH_V) begin
        q <= mem[addr];
      end else begin
        q <= '0;
      end
    end
  end

endmodule

// File: rtl/me_mem_server.sv
// Memory server for the motion estimator: streams in R and S blocks, serves
// engine reads, runs the engine and holds its result. Optional watchdog via
// the ME_MEM_SERVER_WDOG_EN macro.
module me_mem_server
  import me_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [PIX_W-1:0] ld_data,
  output logic             start,
  input  logic [R_AW-1:0]  AddressR,
  input  logic [S_AW-1:0]  AddressS1,
  input  logic [S_AW-1:0]  AddressS2,
  output logic [PIX_W-1:0] R,
  output logic [PIX_W-1:0] S1,
  output logic [PIX_W-1:0] S2,
  input  logic [7:0]       BestDist,
  input  logic [3:0]       motionX,
  input  logic [3:0]       motionY,
  input  logic             completed,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_dist,
  output logic [3:0]       res_mx,
  output logic [3:0]       res_my,
  output logic             err
);

  me_state_t         state, state_nxt;
  logic [S_AW-1:0]   ld_cnt, ld_cnt_nxt;
  logic              ld_fire;
  logic              capture;
  logic              release_res;
  logic              wd_trip;
  logic              r_we;
  logic              s_we;
  logic [2*PIX_W-1:0] s_rdata;

  assign ld_ready = reset_n && (state == IDLE || state == LOAD_R || state == LOAD_S);
  assign ld_fire  = ld_valid && ld_ready;
  assign start    = (state == RUN);
  // A byte accepted in IDLE is already R byte 0.
  assign r_we     = ld_fire && (state == IDLE || state == LOAD_R);
  assign s_we     = ld_fire && (state == LOAD_S);

  me_frame_ram #(
    .DEPTH(R_SIZE),
    .AW   (R_AW),
    .DW   (PIX_W),
    .NRD  (1)
  ) u_rmem (
    .clk  (clock),
    .rst_n(reset_n),
    .we   (r_we),
    .waddr(ld_cnt[R_AW-1:0]),
    .wdata(ld_data),
    .raddr(AddressR),
    .rdata(R)
  );

  me_frame_ram #(
    .DEPTH(S_SIZE),
    .AW   (S_AW),
    .DW   (PIX_W),
    .NRD  (2)
  ) u_smem (
    .clk  (clock),
    .rst_n(reset_n),
    .we   (s_we),
    .waddr(ld_cnt),
    .wdata(ld_data),
    .raddr({AddressS2, AddressS1}),
    .rdata(s_rdata)
  );

  assign S1 = s_rdata[PIX_W-1:0];
  assign S2 = s_rdata[2*PIX_W-1:PIX_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ld_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ld_cnt <= ld_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ld_cnt_nxt  = ld_cnt;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE, LOAD_R: begin
        if (ld_fire) begin
          if (ld_cnt == R_LAST) begin
            state_nxt  = LOAD_S;
            ld_cnt_nxt = '0;
          end else begin
            state_nxt  = LOAD_R;
            ld_cnt_nxt = ld_cnt + S_AW'(1);
          end
        end
      end
      LOAD_S: begin
        if (ld_fire) begin
          if (ld_cnt == S_LAST) begin
            state_nxt  = RUN;
            ld_cnt_nxt = '0;
          end else begin
            ld_cnt_nxt = ld_cnt + S_AW'(1);
          end
        end
      end
      RUN: begin
        if (completed) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end else if (wd_trip) begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (res_valid && res_ready) begin
          state_nxt   = IDLE;
          release_res = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_dist  <= '0;
      res_mx    <= '0;
      res_my    <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_dist  <= BestDist;
      res_mx    <= motionX;
      res_my    <= motionY;
    end else if (release_res) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ME_MEM_SERVER_WDOG_EN
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

  logic [WDOG_W-1:0] wd_cnt;

  // Counter sits at zero outside RUN, so every RUN entry starts from zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == RUN) begin
      wd_cnt <= wd_cnt + WDOG_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  assign wd_trip = (state == RUN) && !completed && (wd_cnt == WDOG_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err <= 1'b0;
    end else if (wd_trip) begin
      err <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_me_mem_server.sv
// Directed self-checking bench for me_mem_server: load, reads, result
// handshake, gapped load, mid-load reset and watchdog behaviour.
module tb_me_mem_server;

  logic       clock;
  logic       reset_n;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_data;
  logic       start;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic [7:0] R, S1, S2;
  logic [7:0] BestDist;
  logic [3:0] motionX, motionY;
  logic       completed;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_dist;
  logic [3:0] res_mx, res_my;
  logic       err;

  int errors = 0;
  int checks = 0;
  int ldIdx  = 0;

  me_mem_server dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .start    (start),
    .AddressR (AddressR),
    .AddressS1(AddressS1),
    .AddressS2(AddressS2),
    .R        (R),
    .S1       (S1),
    .S2       (S2),
    .BestDist (BestDist),
    .motionX  (motionX),
    .motionY  (motionY),
    .completed(completed),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_dist (res_dist),
    .res_mx   (res_mx),
    .res_my   (res_my),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream byte k is k for R, (k-256) mod 256 for S, xor a per-load key.
  function automatic logic [7:0] byteFor(input int k, input logic [7:0] key);
    int v;
    v = (k < 256) ? k : ((k - 256) % 256);
    return 8'(v) ^ key;
  endfunction

  task automatic loadBytes(input int n, input bit gappy, input logic [7:0] key);
    int done;
    int cycles;
    bit fire;
    bit phase;
    done   = 0;
    cycles = 0;
    phase  = 1'b0;
    while (done < n && cycles < 4000) begin
      @(negedge clock);
      ld_valid = gappy ? phase : 1'b1;
      phase    = !phase;
      ld_data  = byteFor(ldIdx, key);
      #1 fire  = ld_valid && ld_ready;
      @(posedge clock);
      if (fire) begin
        done++;
        ldIdx++;
      end
      cycles++;
    end
    #1 ld_valid = 1'b0;
    if (done < n) checkOutput("load_timeout", done, n);
  endtask

  task automatic applyStimulus(input logic [7:0] aR, input logic [9:0] a1, input logic [9:0] a2);
    @(negedge clock);
    AddressR  = aR;
    AddressS1 = a1;
    AddressS2 = a2;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = '0;
    AddressR  = '0;
    AddressS1 = '0;
    AddressS2 = '0;
    BestDist  = '0;
    motionX   = '0;
    motionY   = '0;
    completed = 1'b0;
    res_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_ld_ready", ld_ready, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_R", R, 0);
    checkOutput("rst_S1", S1, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 checkOutput("idle_ld_ready", ld_ready, 1);

    // Full load, checking the boundary on the last byte.
    ldIdx = 0;
    loadBytes(1216, 1'b0, 8'h00);
    checkOutput("pre_last_start", start, 0);
    checkOutput("pre_last_ld_ready", ld_ready, 1);
    loadBytes(1, 1'b0, 8'h00);
    checkOutput("load_ld_ready", ld_ready, 0);
    checkOutput("load_start", start, 1);

    applyStimulus(8'd37, 10'd300, 10'd961);
    checkOutput("rd_R37", R, 8'd37);
    checkOutput("rd_S1_300", S1, 8'd44);
    checkOutput("rd_S2_961", S2, 8'h00);
    applyStimulus(8'd255, 10'd960, 10'd960);
    checkOutput("rd_R255", R, 8'd255);
    checkOutput("rd_S1_960", S1, 8'd192);
    checkOutput("rd_S2_960", S2, 8'd192);
    @(negedge clock);
    AddressR  = 8'd200;
    AddressS2 = 10'd1023;
    #1 checkOutput("rd_latency_R", R, 8'd255);
    @(posedge clock);
    #1;
    checkOutput("rd_R200", R, 8'd200);
    checkOutput("rd_S2_1023", S2, 8'h00);

    // Result capture and hold with res_ready low.
    @(negedge clock);
    completed = 1'b1;
    BestDist  = 8'd12;
    motionX   = 4'b1101;
    motionY   = 4'd5;
    @(posedge clock);
    #1;
    checkOutput("cap_valid", res_valid, 1);
    checkOutput("cap_dist", res_dist, 8'd12);
    checkOutput("cap_mx", res_mx, 4'b1101);
    checkOutput("cap_my", res_my, 4'd5);
    checkOutput("cap_start", start, 0);
    @(negedge clock);
    completed = 1'b0;
    BestDist  = 8'd99;
    motionX   = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      checkOutput("hold_valid", res_valid, 1);
      checkOutput("hold_dist", res_dist, 8'd12);
      checkOutput("hold_mx", res_mx, 4'b1101);
      checkOutput("hold_start", start, 0);
    end
    @(negedge clock);
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("rel_valid", res_valid, 0);
    checkOutput("rel_idle", ld_ready, 1);

    // completed outside RUN must be ignored.
    @(negedge clock);
    res_ready = 1'b0;
    completed = 1'b1;
    BestDist  = 8'd77;
    @(posedge clock);
    #1;
    checkOutput("ign_valid", res_valid, 0);
    checkOutput("ign_dist", res_dist, 8'd12);
    checkOutput("ign_start", start, 0);
    @(negedge clock);
    completed = 1'b0;

    // Gapped load with new data overwrites from address 0.
    ldIdx = 0;
    loadBytes(1217, 1'b1, 8'hA5);
    checkOutput("gap_start", start, 1);
    checkOutput("gap_ld_ready", ld_ready, 0);
    applyStimulus(8'd37, 10'd300, 10'd0);
    checkOutput("gap_R37", R, 8'h80);
    checkOutput("gap_S1_300", S1, 8'h89);
    checkOutput("gap_S2_0", S2, 8'hA5);

    // res_ready high in the capture cycle does not complete the transfer.
    @(negedge clock);
    completed = 1'b1;
    res_ready = 1'b1;
    BestDist  = 8'd200;
    motionX   = 4'b0111;
    motionY   = 4'b1000;
    @(posedge clock);
    #1;
    checkOutput("cap2_valid", res_valid, 1);
    checkOutput("cap2_dist", res_dist, 8'd200);
    checkOutput("cap2_my", res_my, 4'b1000);
    @(negedge clock);
    completed = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("rel2_valid", res_valid, 0);
    checkOutput("rel2_idle", ld_ready, 1);
    @(negedge clock);
    res_ready = 1'b0;

    // Reset at S byte 100 aborts the load.
    ldIdx = 0;
    loadBytes(356, 1'b0, 8'h00);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_ld_ready", ld_ready, 0);
    checkOutput("abort_start", start, 0);
    checkOutput("abort_res_dist", res_dist, 0);
    checkOutput("abort_res_my", res_my, 0);
    checkOutput("abort_S2", S2, 0);
    checkOutput("abort_err", err, 0);
    @(negedge clock);
    reset_n = 1'b1;
    ldIdx = 0;
    loadBytes(1216, 1'b0, 8'h00);
    checkOutput("reload_pre_start", start, 0);
    loadBytes(1, 1'b0, 8'h00);
    checkOutput("reload_start", start, 1);

    // Watchdog: currently in RUN cycle 1; completed held low.
    repeat (4094) @(posedge clock);
    #1;
    checkOutput("wd_4095_start", start, 1);
    checkOutput("wd_4095_err", err, 0);
    @(posedge clock);
    #1;
`ifdef ME_MEM_SERVER_WDOG_EN
    checkOutput("wd_trip_start", start, 0);
    checkOutput("wd_trip_err", err, 1);
    checkOutput("wd_trip_idle", ld_ready, 1);
`else
    checkOutput("wd_off_start", start, 1);
    checkOutput("wd_off_err", err, 0);
`endif

    applyStimulus(8'd37, 10'd300, 10'd961);
    checkOutput("final_R37", R, 8'd37);
    checkOutput("final_S1_300", S1, 8'd44);
    checkOutput("final_S2_961", S2, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/me_mem_server.md
ME_MEM_SERVER -- requirements
Module: me_mem_server

Interface
REQ-001 clock  input  1  single system clock; all state on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 ld_valid / ld_ready / ld_data  input / output / input  1 / 1 / 8  byte load stream; transfer when ld_valid && ld_ready.
REQ-004 start  output  1  run request to motion-estimator engine.
REQ-005 AddressR  input  8  engine reference-block read address (16x16, 256 pixels).
REQ-006 AddressS1, AddressS2  input  10 each  engine search-window read addresses (31x31, 961 pixels).
REQ-007 R, S1, S2  output  8 each  registered read data.
REQ-008 BestDist / motionX / motionY / completed  input  8 / 4 signed / 4 signed / 1  engine result.
REQ-009 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-010 res_dist / res_mx / res_my  output  8 / 4 / 4  captured result.
REQ-011 err  output  1  watchdog error flag.

Function
REQ-012 FSM states IDLE, LOAD_R, LOAD_S, RUN, HOLD; reset state IDLE.
REQ-013 IDLE -> LOAD_R when ld_valid=1; ld_ready=1 in IDLE, LOAD_R, LOAD_S only.
REQ-014 LOAD_R: byte k (k=0..255) written to Rmem[k]; after byte 255 -> LOAD_S same cycle as that transfer completes.
REQ-015 LOAD_S: byte k (k=0..960) written to Smem[k]; after byte 960 -> RUN.
REQ-016 start=1 exactly while in RUN; first RUN cycle is the cycle after the last S write.
REQ-017 R, S1, S2 = memory contents at address sampled on previous clock edge (1-cycle latency), every cycle regardless of state.
REQ-018 AddressS1/S2 >= 961 return 8'h00; no wrap.
REQ-019 Simultaneous S1/S2 reads of the same address return identical data.
REQ-020 RUN: on completed=1, capture BestDist/motionX/motionY into res_*, set res_valid, start=0 next cycle, -> HOLD.
REQ-021 HOLD: res_*/res_valid stable until res_ready=1; on res_valid && res_ready, res_valid=0 next cycle, -> IDLE.
REQ-022 res_valid and res_ready same cycle as capture: no transfer; res_ready evaluated from the following cycle.
REQ-023 completed ignored outside RUN.
REQ-024 Memory contents persist across runs; a new load overwrites from address 0.

Reset
REQ-025 reset_n=0 mid-operation aborts immediately: state IDLE, load counters 0, start=0, ld_ready=0 while reset asserted, res_valid=0, res_*=0, err=0, R/S1/S2=0.
REQ-026 Memory arrays not reset; contents undefined until loaded.

Configuration
REQ-027 Macro ME_MEM_SERVER_WDOG_EN.
REQ-028 Defined: 13-bit counter clears on entering RUN, increments each RUN cycle; reaching 4095 without completed sets err=1 (sticky until reset), start=0, -> IDLE.
REQ-029 Undefined: no counter; err tied 0; RUN waits indefinitely.

Structure
REQ-030 Package me_pkg: R_SIZE=256, S_SIZE=961, pixel width 8, address widths 8/10, FSM state enum, WDOG_LIMIT=4095.
REQ-031 Sub-module me_frame_ram: parameterised depth, one write port, parameterised count of synchronous read ports; instanced once for R (1 read), once for S (2 reads).

Verification
REQ-032 Load R[k]=k, S[k]=k mod 256 -> ld_ready drops after 1217 transfers, start=1 on the next cycle.
REQ-033 After load, AddressR=8'd37 at edge n -> R=8'd37 at edge n+1; AddressS1=10'd300, AddressS2=10'd961 -> S1=8'd44, S2=8'h00.
REQ-034 In RUN drive completed=1, BestDist=8'd12, motionX=-3, motionY=5 with res_ready=0 for 4 cycles -> res_valid=1, res_dist=12, res_mx=4'b1101, res_my=5 held stable; start=0; res_ready=1 -> res_valid=0 next cycle, state IDLE.
REQ-035 Deassert ld_valid every other cycle during load -> load still completes after 1217 accepted bytes, data correct.
REQ-036 reset_n=0 at byte 100 of LOAD_S -> all outputs at reset values; reload of 1217 bytes required before start=1.
REQ-037 ME_MEM_SERVER_WDOG_EN defined, completed never asserted -> err=1 and start=0 at RUN cycle 4096; undefined -> start stays 1, err=0.
